watch_time_counter: RTL and testbench

- Consumes the single-cycle 100 Hz tick from the tick generator and keeps wall-clock time as centiseconds, seconds, minutes and hours.
- Accepts run/stop, clear and per-field "up" adjust pulses from the debounced button path.
- Drives the registered time fields consumed by the display mux/FND controller.
- Emits a day-rollover pulse.

---
 rtl/watch_time_counter.sv | 86 ++++++++
 tb/tb_watch_time_counter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/watch_time_counter.sv
// Wall-clock time keeper: counts 100 Hz ticks into centiseconds, seconds, minutes, hours.
// Adjust pulses bump a single field without carrying; only the tick chain produces carries.
module watch_time_counter #(
    parameter int MSEC_MAX  = 100,
    parameter int SEC_MAX   = 60,
    parameter int MIN_MAX   = 60,
    parameter int HOUR_MAX  = 24,
    parameter int HOUR_INIT = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_tick,
    input  logic                        i_run,
    input  logic                        i_clear,
    input  logic                        i_sec_up,
    input  logic                        i_min_up,
    input  logic                        i_hour_up,
    output logic [$clog2(MSEC_MAX)-1:0] o_msec,
    output logic [$clog2(SEC_MAX)-1:0]  o_sec,
    output logic [$clog2(MIN_MAX)-1:0]  o_min,
    output logic [$clog2(HOUR_MAX)-1:0] o_hour,
    output logic                        o_day_carry
);

    localparam int MW = $clog2(MSEC_MAX);
    localparam int SW = $clog2(SEC_MAX);
    localparam int NW = $clog2(MIN_MAX);
    localparam int HW = $clog2(HOUR_MAX);

    logic [MW-1:0] msec_q, msec_d;
    logic [SW-1:0] sec_q, sec_d;
    logic [NW-1:0] min_q, min_d;
    logic [HW-1:0] hour_q, hour_d;
    logic          day_q;

    logic          tick_en;
    logic          msec_carry, sec_carry, min_carry, hour_carry;
    logic [SW:0]   sec_sum;
    logic [NW:0]   min_sum;
    logic [HW:0]   hour_sum;

    assign tick_en    = i_tick & i_run;
    assign msec_carry = tick_en & (msec_q == MW'(MSEC_MAX - 1));
    assign sec_carry  = msec_carry & (sec_q == SW'(SEC_MAX - 1));
    assign min_carry  = sec_carry & (min_q == NW'(MIN_MAX - 1));
    assign hour_carry = min_carry & (hour_q == HW'(HOUR_MAX - 1));

    // Increment is at most 2 (carry + up), so a single conditional subtract wraps correctly.
    assign sec_sum  = {1'b0, sec_q} + {{SW{1'b0}}, msec_carry} + {{SW{1'b0}}, i_sec_up};
    assign min_sum  = {1'b0, min_q} + {{NW{1'b0}}, sec_carry} + {{NW{1'b0}}, i_min_up};
    assign hour_sum = {1'b0, hour_q} + {{HW{1'b0}}, min_carry} + {{HW{1'b0}}, i_hour_up};

    always_comb begin
        msec_d = msec_q;
        if (tick_en) begin
            msec_d = msec_carry ? '0 : msec_q + MW'(1);
        end
        sec_d  = (sec_sum >= (SW+1)'(SEC_MAX)) ? SW'(sec_sum - (SW+1)'(SEC_MAX)) : sec_sum[SW-1:0];
        min_d  = (min_sum >= (NW+1)'(MIN_MAX)) ? NW'(min_sum - (NW+1)'(MIN_MAX)) : min_sum[NW-1:0];
        hour_d = (hour_sum >= (HW+1)'(HOUR_MAX)) ? HW'(hour_sum - (HW+1)'(HOUR_MAX))
                                                  : hour_sum[HW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            msec_q <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= HW'(HOUR_INIT);
            day_q  <= 1'b0;
        end else begin
            msec_q <= msec_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
            day_q  <= hour_carry;
        end
    end

    assign o_msec      = msec_q;
    assign o_sec       = sec_q;
    assign o_min       = min_q;
    assign o_hour      = hour_q;
    assign o_day_carry = day_q;

endmodule

// File: tb/tb_watch_time_counter.sv
// Directed bench for watch_time_counter: the driver pushes hand-computed time snapshots,
// a negedge monitor pops and compares them against the registered outputs.
module tb_watch_time_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       run = 1'b0;
  logic       clear = 1'b0;
  logic       sec_up = 1'b0;
  logic       min_up = 1'b0;
  logic       hour_up = 1'b0;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] minute;
  logic [4:0] hour;
  logic       day_carry;

  int checks = 0;
  int passed = 0;

  logic [24:0] exp_q[$];
  string       name_q[$];

  watch_time_counter dut (
    .clk         (clk),
    .rst         (rst),
    .i_tick      (tick),
    .i_run       (run),
    .i_clear     (clear),
    .i_sec_up    (sec_up),
    .i_min_up    (min_up),
    .i_hour_up   (hour_up),
    .o_msec      (msec),
    .o_sec       (sec),
    .o_min       (minute),
    .o_hour      (hour),
    .o_day_carry (day_carry)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d passed=%0d)", checks, passed);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [24:0] pk(input int h, input int m, input int s, input int ms, input int d);
    pk = {5'(h), 6'(m), 6'(s), 7'(ms), 1'(d)};
  endfunction

  // driver: one clock cycle with the given pulses, inputs applied at negedge
  task automatic cyc(input bit t, input bit c, input bit su, input bit mu, input bit hu, input bit r);
    @(negedge clk);
    tick = t; clear = c; sec_up = su; min_up = mu; hour_up = hu; rst = r;
    @(posedge clk);
    #1;
    tick = 1'b0; clear = 1'b0; sec_up = 1'b0; min_up = 1'b0; hour_up = 1'b0; rst = 1'b0;
  endtask

  task automatic expect_state(input string nm, input int h, input int m, input int s, input int ms, input int d);
    exp_q.push_back(pk(h, m, s, ms, d));
    name_q.push_back(nm);
  endtask

  task automatic repeat_cyc(input int n, input bit t, input bit su, input bit mu, input bit hu);
    for (int i = 0; i < n; i++) cyc(t, 1'b0, su, mu, hu, 1'b0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [24:0] e;
      logic [24:0] a;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {hour, minute, sec, msec, day_carry};
      checks++;
      if (a === e) passed++;
      else $display("FAIL %s: got %0d:%0d:%0d.%0d day=%0d, required %0d:%0d:%0d.%0d day=%0d", nm,
                    a[24:20], a[19:14], a[13:8], a[7:1], a[0], e[24:20], e[19:14], e[13:8], e[7:1], e[0]);
    end
  end

  initial begin
    // reset
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    expect_state("reset", 12, 0, 0, 0, 0);

    // run with a tick every 10 clocks for 100 ticks
    run = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      expect_state("tick_count", 12, 0, i / 100, i % 100, 0);
      repeat_cyc(9, 0, 0, 0, 0);
    end

    // run low: ticks ignored, adjust still honoured, no day carry from minute wraps
    run = 1'b0;
    repeat_cyc(50, 1, 0, 0, 0);
    expect_state("hold", 12, 0, 1, 0, 0);
    for (int k = 1; k <= 61; k++) begin
      cyc(0, 0, 0, 1, 0, 0);
      expect_state("min_up_wrap", 12, k % 60, 1, 0, 0);
    end

    // build 12:58:59.99 from 12:01:01.00
    repeat_cyc(57, 0, 0, 1, 0);
    repeat_cyc(58, 0, 1, 0, 0);
    run = 1'b1;
    repeat_cyc(99, 1, 0, 0, 0);
    expect_state("setup_12_58_59_99", 12, 58, 59, 99, 0);
    // sec carry reaches minutes (58+1+1 wraps to 0) but min was not 59, so no hour carry
    cyc(1, 0, 0, 1, 0, 0);
    expect_state("tick_plus_min_up", 12, 0, 0, 0, 0);

    // build 23:59:59.99; also hour_up wrap must not raise day carry
    run = 1'b0;
    repeat_cyc(11, 0, 0, 0, 1);
    expect_state("hour_23", 23, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    expect_state("hour_up_wrap", 0, 0, 0, 0, 0);
    repeat_cyc(23, 0, 0, 0, 1);
    repeat_cyc(59, 0, 0, 1, 0);
    repeat_cyc(59, 0, 1, 0, 0);
    run = 1'b1;
    repeat_cyc(99, 1, 0, 0, 0);
    expect_state("setup_23_59_59_99", 23, 59, 59, 99, 0);
    cyc(1, 0, 0, 0, 0, 0);
    expect_state("day_rollover", 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    expect_state("day_carry_one_cycle", 0, 0, 0, 0, 0);

    // +2 on seconds from 59: tick carry plus sec_up -> 1, minutes bumped by carry
    repeat_cyc(59, 0, 1, 0, 0);
    repeat_cyc(99, 1, 0, 0, 0);
    expect_state("setup_00_00_59_99", 0, 0, 59, 99, 0);
    cyc(1, 0, 1, 0, 0, 0);
    expect_state("sec_plus_two", 0, 1, 1, 0, 0);

    // clear mid-count together with tick and sec_up
    cyc(0, 1, 0, 0, 0, 0);
    expect_state("clear_plain", 12, 0, 0, 0, 0);
    run = 1'b0;
    repeat_cyc(34, 0, 0, 1, 0);
    repeat_cyc(56, 0, 1, 0, 0);
    run = 1'b1;
    repeat_cyc(78, 1, 0, 0, 0);
    expect_state("setup_12_34_56_78", 12, 34, 56, 78, 0);
    cyc(1, 1, 1, 0, 0, 0);
    expect_state("clear_priority", 12, 0, 0, 0, 0);

    // reset during a tick/adjust burst, then counting resumes
    repeat_cyc(3, 1, 1, 0, 0);
    expect_state("burst", 12, 0, 3, 3, 0);
    cyc(1, 0, 0, 1, 1, 1);
    expect_state("rst_in_burst", 12, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    expect_state("resume_after_rst", 12, 0, 0, 1, 0);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
